// File: rtl/mips_cpu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mips_cpu_ctrl_fsm
//
// Multicycle sequencer for the MIPS core. It steps each instruction through
// fetch, execute, optional memory access and writeback. It drives the
// Avalon-style memory strobes, the IR/MDR/register-file write enables and the
// PC-unit update controls. It stops on a fetch from address 0, or when a bus
// access stalls for too long. It also counts retired instructions.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   waitrequest  memory stall; an access completes in a cycle where this is 0
//   pc_is_zero   PC unit currently points at address 0x00000000
//   dec_load     decoded instruction is a load
//   dec_store    decoded instruction is a store
//   dec_branch   decoded conditional branch
//   br_taken     branch condition true (valid in WB)
//   dec_jump     J/JAL
//   dec_jr       JR/JALR
//   dec_regwrite instruction writes the register file
//   mem_read     memory read strobe
//   mem_write    memory write strobe
//   addr_sel     0 = PC drives the address, 1 = ALU result drives the address
//   ir_en        latch readdata into the instruction register
//   mdr_en       latch readdata into the memory-data register
//   reg_write    register-file write enable
//   pc_en        PC unit advances this cycle
//   pc_ctrl      0 = +4, 1 = branch, 2 = jump, 3 = jump-register
//   active       CPU running
//   bus_err      sticky bus-stall watchdog error
//   state        current state (debug)
//   instr_count  retired instruction count (wraps)
//
// state | meaning
// ------+--------------------------------------------------------------
// FETCH | read instruction at PC; halt instead if PC == 0
// EXEC  | decode/ALU cycle, no bus activity
// MEM   | load/store data access at the ALU-computed address
// WB    | register write, PC update, retire
// HALT  | stopped (fetch from 0 or bus timeout), left only by rst
// -----------------------------------------------------------------------------
module mips_cpu_ctrl_fsm #(
    parameter int unsigned WAIT_LIMIT = 256,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             waitrequest,
    input  logic             pc_is_zero,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_branch,
    input  logic             br_taken,
    input  logic             dec_jump,
    input  logic             dec_jr,
    input  logic             dec_regwrite,
    output logic             mem_read,
    output logic             mem_write,
    output logic             addr_sel,
    output logic             ir_en,
    output logic             mdr_en,
    output logic             reg_write,
    output logic             pc_en,
    output logic [1:0]       pc_ctrl,
    output logic             active,
    output logic             bus_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } state_t;

    // The stall counter only has to reach WAIT_LIMIT-1; hitting it with
    // waitrequest still high leaves the state, which clears the counter.
    localparam int unsigned     WC_W    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam bit              WD_EN   = (WAIT_LIMIT > 0);
    localparam logic [WC_W-1:0] WC_LAST = WD_EN ? WC_W'(WAIT_LIMIT - 1) : '0;

    state_t            state_q;
    state_t            state_d;
    logic              active_q;
    logic              bus_err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WC_W-1:0]   wait_cnt_q;

    logic              bus_busy;
    logic              timeout;
    logic              go_halt;
    logic              set_err;
    logic              retire;

    // A bus access is pending only when a read or write is actually issued.
    // A FETCH from address 0 issues no read, so it can never time out.
    assign bus_busy = ((state_q == FETCH) && !pc_is_zero) || (state_q == MEM);
    assign timeout  = WD_EN && bus_busy && waitrequest && (wait_cnt_q == WC_LAST);

    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr_sel  = 1'b0;
        ir_en     = 1'b0;
        mdr_en    = 1'b0;
        reg_write = 1'b0;
        pc_en     = 1'b0;
        pc_ctrl   = 2'd0;
        go_halt   = 1'b0;
        set_err   = 1'b0;
        retire    = 1'b0;

        case (state_q)
            FETCH: begin
                if (pc_is_zero) begin
                    state_d = HALT;
                    go_halt = 1'b1;
                end else begin
                    mem_read = 1'b1;
                    if (!waitrequest) begin
                        ir_en   = 1'b1;
                        state_d = EXEC;
                    end else if (timeout) begin
                        state_d = HALT;
                        go_halt = 1'b1;
                        set_err = 1'b1;
                    end
                end
            end
            EXEC: begin
                state_d = (dec_load || dec_store) ? MEM : WB;
            end
            MEM: begin
                addr_sel  = 1'b1;
                mem_read  = dec_load;
                // A load takes priority if the decoder flags both.
                mem_write = dec_store && !dec_load;
                if (!waitrequest) begin
                    mdr_en  = dec_load;
                    state_d = WB;
                end else if (timeout) begin
                    state_d = HALT;
                    go_halt = 1'b1;
                    set_err = 1'b1;
                end
            end
            WB: begin
                reg_write = dec_regwrite;
                pc_en     = 1'b1;
                // The PC unit handles the delay slot by applying a non-zero
                // pc_ctrl one update later. So the controller issues pc_ctrl
                // in the branching instruction's own WB.
                if (dec_jr)
                    pc_ctrl = 2'd3;
                else if (dec_jump)
                    pc_ctrl = 2'd2;
                else if (dec_branch && br_taken)
                    pc_ctrl = 2'd1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // During reset no bus or write strobe may escape, whatever the state.
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_en     = 1'b0;
            mdr_en    = 1'b0;
            reg_write = 1'b0;
            pc_en     = 1'b0;
            pc_ctrl   = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            active_q   <= 1'b1;
            bus_err_q  <= 1'b0;
            cnt_q      <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (go_halt)
                active_q <= 1'b0;
            if (set_err)
                bus_err_q <= 1'b1;
            if (retire)
                cnt_q <= cnt_q + CNT_W'(1);
            if ((state_d != state_q) || !waitrequest)
                wait_cnt_q <= '0;
            else if (WD_EN && bus_busy)
                wait_cnt_q <= wait_cnt_q + WC_W'(1);
        end
    end

    assign active      = active_q;
    assign bus_err     = bus_err_q;
    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_cpu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_ctrl_fsm
//
// Drives whole instructions into the sequencer and compares every cycle
// against an instruction-level timeline. The timeline is built from the
// instruction's class and its wait-state counts.
// -----------------------------------------------------------------------------
module tb_mips_cpu_ctrl_fsm;

    localparam int CW = 8;
    localparam int WL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          waitrequest = 1'b0;
    logic          pc_is_zero = 1'b0;
    logic          dec_load = 1'b0;
    logic          dec_store = 1'b0;
    logic          dec_branch = 1'b0;
    logic          br_taken = 1'b0;
    logic          dec_jump = 1'b0;
    logic          dec_jr = 1'b0;
    logic          dec_regwrite = 1'b0;
    logic          mem_read;
    logic          mem_write;
    logic          addr_sel;
    logic          ir_en;
    logic          mdr_en;
    logic          reg_write;
    logic          pc_en;
    logic [1:0]    pc_ctrl;
    logic          active;
    logic          bus_err;
    logic [2:0]    state;
    logic [CW-1:0] instr_count;

    int            checks = 0;
    int            failures = 0;
    logic [CW-1:0] model_cnt = '0;

    // decode vector order: {ld, st, br, tk, jp, jr, rw}
    localparam logic [6:0] D_ALU = 7'b0000001;
    localparam logic [6:0] D_ST  = 7'b0100000;

    mips_cpu_ctrl_fsm #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .waitrequest  (waitrequest),
        .pc_is_zero   (pc_is_zero),
        .dec_load     (dec_load),
        .dec_store    (dec_store),
        .dec_branch   (dec_branch),
        .br_taken     (br_taken),
        .dec_jump     (dec_jump),
        .dec_jr       (dec_jr),
        .dec_regwrite (dec_regwrite),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .addr_sel     (addr_sel),
        .ir_en        (ir_en),
        .mdr_en       (mdr_en),
        .reg_write    (reg_write),
        .pc_en        (pc_en),
        .pc_ctrl      (pc_ctrl),
        .active       (active),
        .bus_err      (bus_err),
        .state        (state),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [21:0] obs();
        return {state, mem_read, mem_write, addr_sel, ir_en, mdr_en, reg_write,
                pc_en, pc_ctrl, active, bus_err, instr_count};
    endfunction

    function automatic logic [21:0] mk(input logic [2:0] s, input logic mr, mw, as, ir, md, rw, pe,
                                       input logic [1:0] pc, input logic act, be,
                                       input logic [CW-1:0] c);
        return {s, mr, mw, as, ir, md, rw, pe, pc, act, be, c};
    endfunction

    // One clock cycle: inputs change just after the rising edge and outputs
    // are sampled on the falling edge.
    task automatic cyc(input logic r, input logic w, input logic pz, input logic [6:0] d);
        @(posedge clk);
        #1;
        rst          = r;
        waitrequest  = w;
        pc_is_zero   = pz;
        {dec_load, dec_store, dec_branch, br_taken, dec_jump, dec_jr, dec_regwrite} = d;
        @(negedge clk);
    endtask

    // Executes one instruction and checks every cycle of it. Expected outputs
    // come from the instruction's class: fw stall cycles and one completing
    // fetch cycle, one execute cycle, mw stall cycles and one completing cycle
    // for a load/store, then one writeback cycle.
    task automatic run_instr(input logic [6:0] d, input int fw, input int mw, input string tag);
        logic       ld, st, br, tk, jp, jr, rw, w;
        logic [1:0] pcc;
        logic [21:0] e;
        logic [21:0] got;
        {ld, st, br, tk, jp, jr, rw} = d;
        for (int i = 0; i <= fw; i++) begin
            w = (i < fw);
            cyc(1'b0, w, 1'b0, 7'($urandom));
            e = mk(3'd0, 1'b1, 1'b0, 1'b0, !w, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, model_cnt);
            got = obs();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s fetch[%0d]: got=%h exp=%h", tag, i, got, e);
            end
        end
        cyc(1'b0, 1'($urandom), 1'b0, d);
        e = mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, model_cnt);
        got = obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s exec: got=%h exp=%h", tag, got, e);
        end
        if (ld || st) begin
            for (int i = 0; i <= mw; i++) begin
                w = (i < mw);
                cyc(1'b0, w, 1'b0, d);
                e = mk(3'd2, ld, st && !ld, 1'b1, 1'b0, ld && !w, 1'b0, 1'b0, 2'd0,
                       1'b1, 1'b0, model_cnt);
                got = obs();
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s mem[%0d]: got=%h exp=%h", tag, i, got, e);
                end
            end
        end
        pcc = jr ? 2'd3 : jp ? 2'd2 : (br && tk) ? 2'd1 : 2'd0;
        cyc(1'b0, 1'($urandom), 1'b0, d);
        e = mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rw, 1'b1, pcc, 1'b1, 1'b0, model_cnt);
        got = obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s wb: got=%h exp=%h", tag, got, e);
        end
        model_cnt = model_cnt + 1'b1;
    endtask

    task automatic test_reset();
        logic [21:0] e;
        logic [21:0] got;
        cyc(1'b1, 1'b0, 1'b0, 7'h7F);
        cyc(1'b1, 1'b0, 1'b0, 7'h7F);
        model_cnt = '0;
        e = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, '0);
        got = obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_state: got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_alu();
        run_instr(D_ALU, 0, 0, "addu0");
        run_instr(D_ALU, 0, 0, "addu1");
    endtask

    task automatic test_load_wait();
        run_instr(7'b1000001, 0, 2, "lw_wait2");
    endtask

    task automatic test_store_branch_jr();
        run_instr(D_ST,       0, 0, "sw");
        run_instr(7'b0011000, 0, 0, "beq_taken");
        run_instr(7'b0010000, 0, 0, "beq_not_taken");
        run_instr(7'b0000010, 0, 0, "jr");
        run_instr(7'b0000111, 0, 0, "jump_and_jr");
        run_instr(7'b0000101, 0, 0, "jal");
        run_instr(7'b0011100, 0, 0, "branch_and_jump");
        run_instr(7'b1100001, 1, 1, "load_and_store");
    endtask

    task automatic test_halt();
        logic [21:0] e;
        logic [21:0] got;
        cyc(1'b0, 1'($urandom), 1'b1, 7'($urandom));
        e = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, model_cnt);
        got = obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL halt_entry: got=%h exp=%h", got, e);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'($urandom), 1'($urandom), 7'($urandom));
            e = mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, model_cnt);
            got = obs();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL halt_hold[%0d]: got=%h exp=%h", i, got, e);
            end
        end
        cyc(1'b1, 1'($urandom), 1'($urandom), 7'($urandom));
        e = mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, model_cnt);
        got = obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL halt_rst_cycle: got=%h exp=%h", got, e);
        end
        cyc(1'b1, 1'($urandom), 1'($urandom), 7'($urandom));
        model_cnt = '0;
        e = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, '0);
        got = obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL halt_release: got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_watchdog_fetch();
        logic [21:0] e;
        logic [21:0] got;
        for (int i = 0; i < WL; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 7'($urandom));
            e = mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, model_cnt);
            got = obs();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL wd_fetch_stall[%0d]: got=%h exp=%h", i, got, e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'($urandom), 1'($urandom), 7'($urandom));
            e = mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, model_cnt);
            got = obs();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL wd_fetch_halt[%0d]: got=%h exp=%h", i, got, e);
            end
        end
        cyc(1'b1, 1'b1, 1'b0, 7'($urandom));
        cyc(1'b1, 1'b1, 1'b0, 7'($urandom));
        model_cnt = '0;
        e = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, '0);
        got = obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL wd_fetch_clear: got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_watchdog_mem();
        logic [21:0] e;
        logic [21:0] got;
        run_instr(D_ALU, 0, 0, "wd_mem_pre");
        cyc(1'b0, 1'b0, 1'b0, 7'($urandom));
        cyc(1'b0, 1'b1, 1'b0, D_ST);
        for (int i = 0; i < WL; i++) begin
            cyc(1'b0, 1'b1, 1'b0, D_ST);
            e = mk(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, model_cnt);
            got = obs();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL wd_mem_stall[%0d]: got=%h exp=%h", i, got, e);
            end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1, 1'b0, D_ST);
            e = mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, model_cnt);
            got = obs();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL wd_mem_halt[%0d]: got=%h exp=%h", i, got, e);
            end
        end
        cyc(1'b1, 1'b0, 1'b0, 7'($urandom));
        cyc(1'b1, 1'b0, 1'b0, 7'($urandom));
        model_cnt = '0;
    endtask

    task automatic test_reset_mid();
        logic [21:0] e;
        logic [21:0] got;
        run_instr(D_ALU, 0, 0, "rstmid_pre");
        cyc(1'b0, 1'b0, 1'b0, 7'($urandom));
        cyc(1'b0, 1'b0, 1'b0, D_ST);
        cyc(1'b0, 1'b1, 1'b0, D_ST);
        e = mk(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, model_cnt);
        got = obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL rstmid_mem_write: got=%h exp=%h", got, e);
        end
        cyc(1'b1, 1'b1, 1'b0, D_ST);
        e = mk(3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, model_cnt);
        got = obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL rstmid_forced: got=%h exp=%h", got, e);
        end
        model_cnt = '0;
        run_instr(D_ALU, 0, 0, "rstmid_resume");
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            run_instr(7'($urandom), $urandom_range(0, WL - 1), $urandom_range(0, WL - 1), "random");
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_store_branch_jr();
        test_halt();
        test_watchdog_fetch();
        test_watchdog_mem();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_cpu_ctrl_fsm.md
Name: mips_cpu_ctrl_fsm

Overview:
Multicycle sequencer for the MIPS core. Drives Avalon-style memory read/write strobes for instruction fetch and data access, and the write-enables for the instruction register, the memory-data register and the register file. Issues the PC-unit update strobe and the 2-bit PC select. Detects halt (fetch from address 0) and bus-stall timeout, and counts retired instructions.

Parameters:
WAIT_LIMIT, 256, max consecutive waitrequest-high cycles in FETCH/MEM before bus error; 0 disables the watchdog.
CNT_W, 32, width of instr_count.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
waitrequest  in  1  memory stall; access completes in a cycle where this is 0
pc_is_zero  in  1  PC unit current address == 0x00000000
dec_load  in  1  decoded instruction is a load
dec_store  in  1  decoded instruction is a store
dec_branch  in  1  decoded conditional branch
br_taken  in  1  branch condition true (valid in WB)
dec_jump  in  1  J/JAL
dec_jr  in  1  JR/JALR
dec_regwrite  in  1  instruction writes the register file
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
addr_sel  out  1  0 = PC drives address, 1 = ALU result drives address
ir_en  out  1  latch readdata into the instruction register
mdr_en  out  1  latch readdata into the memory-data register
reg_write  out  1  register-file write enable
pc_en  out  1  PC unit advances this cycle
pc_ctrl  out  2  0 = +4, 1 = branch, 2 = jump, 3 = jump-register
active  out  1  CPU running
bus_err  out  1  sticky watchdog error
state  out  3  current state (debug)
instr_count  out  CNT_W  retired instructions

Behaviour:
- State encoding: FETCH=0, EXEC=1, MEM=2, WB=3, HALT=4. All transitions occur on posedge clk.
- Reset values: state=FETCH, active=1, bus_err=0, instr_count=0, wait_cnt=0. While rst=1, all strobes (mem_read, mem_write, ir_en, mdr_en, reg_write, pc_en) are forced to 0 and pc_ctrl=0.
- Strobes are combinational from state and inputs. Every strobe not listed for a state is 0, and pc_ctrl=0 outside WB.
- FETCH:
  - If pc_is_zero: no read; next state HALT; active<=0.
  - Otherwise: mem_read=1, addr_sel=0. When waitrequest=0, ir_en=1 and next state is EXEC. When waitrequest=1, stay in FETCH.
- EXEC: no strobes. If dec_load or dec_store, next state MEM; otherwise WB.
- MEM: addr_sel=1. mem_read=dec_load. mem_write=dec_store & ~dec_load (load wins if both set). When waitrequest=0: mdr_en=dec_load and next state is WB. When waitrequest=1, stay in MEM.
- WB:
  - reg_write=dec_regwrite; pc_en=1.
  - pc_ctrl priority: dec_jr→3, else dec_jump→2, else dec_branch&br_taken→1, else 0.
  - instr_count++ (wraps at 2^CNT_W). Next state FETCH.
- Delay slot: the PC unit applies a non-zero pc_ctrl one update later. The controller needs no delay-slot state and always issues pc_ctrl with the branching instruction's own WB.
- HALT: sticky until rst. active=0, all strobes 0, instr_count frozen.
- Watchdog:
  - wait_cnt clears on any state change and in any cycle with waitrequest=0. It increments in FETCH/MEM while waitrequest=1.
  - When wait_cnt==WAIT_LIMIT-1 and waitrequest=1 (WAIT_LIMIT>0): next state HALT, bus_err<=1, active<=0.
  - The strobe is dropped on HALT entry.
- Latency with zero wait states: non-memory instruction = 3 cycles (FETCH, EXEC, WB); load/store = 4 cycles. Each waitrequest cycle adds 1.
- rst mid-operation (e.g. in MEM with mem_write=1): next cycle state=FETCH and mem_write=0. No partial retire; instr_count=0.
- rst in HALT: active returns to 1 and bus_err clears.

Test Plan:
1. Reset, waitrequest=0, ADDU-type decode (dec_regwrite=1): states 0,1,3,0. ir_en pulses in cycle 1 and reg_write+pc_en in cycle 3 with pc_ctrl=0. instr_count=1 after 3 cycles.
2. LW with waitrequest held high 2 cycles in MEM: mem_read=1, addr_sel=1 for 3 cycles; mdr_en only in the third. Total 6 cycles; reg_write in WB.
3. SW then BEQ taken then JR: SW has mem_write=1 for one cycle and reg_write=0. BEQ WB gives pc_ctrl=1. JR WB gives pc_ctrl=3. dec_jump+dec_jr set together gives pc_ctrl=3.
4. pc_is_zero=1 in FETCH: mem_read=0, next cycle state=4 and active=0. Stays halted 10 cycles with instr_count frozen. rst restores active=1.
5. WAIT_LIMIT=4, waitrequest stuck high in FETCH: mem_read high 4 cycles, then state=4, bus_err=1, active=0, mem_read=0.
6. rst asserted during MEM of SW: mem_write drops to 0 the next cycle, state=0, instr_count=0. Normal fetch resumes after rst is released.
